priority_code_encoder: RTL and testbench
========================================

Name: priority_code_encoder

Overview:
- Sequential consumer on the far end of the priority detector interface.
- Accepts the detector's 3-bit one-hot result vector {outZ,outY,outX} under a valid/ready handshake.
- Encodes each vector into a 2-bit class code plus an error flag, and buffers the results in a small first-word-fall-through FIFO.
- Presents the buffered codes to a downstream reporter through a second valid/ready handshake, and flags rejected offers.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers in_onehot this cycle.
- in_ready  output  1  block can accept; combinational, equals !full.
- in_onehot  input  3  detector result; bit0=X, bit1=Y, bit2=Z.
- out_valid  output  1  FIFO head valid; equals !empty.
- out_ready  input  1  downstream takes the head this cycle.
- out_code  output  2  head class: 1=X, 2=Y, 3=Z; 0 when empty.
- out_err  output  1  head entry came from a non-one-hot vector; 0 when empty.
- count  output  CW  current number of stored entries.
- overflow  output  1  sticky flag: an offer was rejected.
- clear_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, synchronous release): pointers=0, count=0, overflow=0. Consequently out_valid=0, out_code=0, out_err=0 and in_ready=1.
- Accept occurs when in_valid && in_ready at a rising edge.
- Encoding at accept:
  - 001 -> code 1, err 0.
  - 010 -> code 2, err 0.
  - 100 -> code 3, err 0.
  - 000 -> accepted but discarded: nothing written, count unchanged.
  - Two or more bits set -> code of the highest set bit (Z>Y>X), err 1. Example: 011 -> code 2, err 1; 111 -> code 3, err 1.
- Entry storage: 3 bits {err,code} per entry, written at the write pointer. The write pointer and count advance only when an entry is actually written.
- Latency: an entry accepted at edge N is visible on out_code/out_err/out_valid after edge N (usable in cycle N+1). There is no bypass when the FIFO is empty.
- Pop occurs when out_valid && out_ready at a rising edge: the read pointer advances and the next head appears after the edge.
- Simultaneous push and pop (not full, not empty): both pointers advance and count is unchanged.
- Full: in_ready=0, and no write happens even if out_ready pops in the same cycle. A pop while full frees one slot, so in_ready=1 from the next cycle.
- Empty: out_valid=0 and out_ready is ignored. A zero vector accepted while empty leaves the FIFO empty.
- Wrap-around: pointers are log2(DEPTH) bits, wrap modulo DEPTH, and ordering is preserved across the wrap.
- Overflow:
  - Set at any edge where in_valid=1 and in_ready=0.
  - Cleared at an edge with clear_ovf=1.
  - If set and clear occur in the same edge, set wins.
  - Overflow does not affect the data path.
- Invariants:
  - count = number of writes minus number of pops, always in the range 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Reset mid-operation: all entries are lost immediately; outputs return to their reset values asynchronously.
- X-safety: with in_valid=0, in_onehot is don't-care and no state changes.

Test Plan:
- Reset then idle → out_valid=0, out_code=0, out_err=0, count=0, in_ready=1, overflow=0.
- Push 001, 010, 100 on consecutive cycles with out_ready=0 → count=3; then out_ready=1 for 3 cycles → out_code sequence 1,2,3 with out_err=0; count returns to 0; out_valid drops after the third pop.
- Push 000, then 011, then 111 → 000 is discarded and count=2; heads read code 2/err 1, then code 3/err 1.
- DEPTH=4: push 4 entries with out_ready=0, then hold in_valid=1 one more cycle → in_ready=0, count=4, overflow=1. Then pulse clear_ovf with in_valid=0 → overflow=0. Then assert clear_ovf while in_valid=1 and in_ready=0 → overflow stays 1.
- Continuous in_valid=1 and out_ready=1 for 10 cycles with the class cycling X,Y,Z → after the first cycle count stays 1, codes emerge in order 1,2,3,1,… delayed one cycle, and pointers wrap without loss.
- With 3 entries stored, assert rst asynchronously mid-cycle → out_valid=0 and count=0 immediately. After release, a push of 100 appears as code 3 one cycle later.

Source files
------------

// File: rtl/priority_code_encoder.sv
// priority_code_encoder: encodes one-hot detector results into {err,code} entries
// and buffers them in a first-word-fall-through FIFO with a sticky overflow flag.
module priority_code_encoder #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_onehot,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_code,
  output logic          out_err,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          clear_ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, full, empty, wr_en, pop;
  logic [2:0]    entry;
  always_comb begin
    full    = count_q == CW'(DEPTH);
    empty   = count_q == '0;
    wr_en   = in_valid && !full && |in_onehot;
    pop     = !empty && out_ready;
    entry   = {(in_onehot[0] & in_onehot[1]) | (in_onehot[0] & in_onehot[2]) | (in_onehot[1] & in_onehot[2]),
               in_onehot[2] ? 2'd3 : in_onehot[1] ? 2'd2 : 2'd1};
    wr_d    = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(wr_en) - CW'(pop);
    ovf_d   = (in_valid && full) || (ovf_q && !clear_ovf);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  // Storage needs no reset: an empty FIFO masks the head to zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= entry;
  end
  always_comb begin
    in_ready            = !full;
    out_valid           = !empty;
    {out_err, out_code} = empty ? 3'b000 : mem_q[rd_q];
    count               = count_q;
    overflow            = ovf_q;
  end
endmodule

// File: tb/tb_priority_code_encoder.sv
// tb_priority_code_encoder: directed and randomized checks against a queue-based model.
module tb_priority_code_encoder;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, clear_ovf = 1'b0;
  logic [2:0] in_onehot = 3'b000;
  logic in_ready, out_valid, out_err, overflow;
  logic [1:0] out_code;
  logic [CW-1:0] count;
  int tests = 0, fails = 0;
  int q[$];
  bit m_ovf = 0;

  priority_code_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_onehot(in_onehot),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_err(out_err),
    .count(count), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  // Reference encoding: highest set bit gives class, more than one set bit is an error.
  function automatic int encode(input logic [2:0] v);
    int hi = -1;
    for (int b = 0; b < 3; b++) if (v[b]) hi = b;
    return (($countones(v) > 1) ? 4 : 0) + hi + 1;
  endfunction

  function automatic int head();
    return q.size() > 0 ? q[0] : 0;
  endfunction

  task automatic cycle(input bit v, input logic [2:0] oh, input bit r, input bit clr);
    bit rdy;
    in_valid = v; in_onehot = oh; out_ready = r; clear_ovf = clr;
    @(posedge clk);
    rdy = q.size() < DEPTH;
    if (v && !rdy) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (q.size() > 0 && r) void'(q.pop_front());
    if (v && rdy && oh != 3'b000) q.push_back(encode(oh));
    #1;
    in_valid = 0; out_ready = 0; clear_ovf = 0; in_onehot = 3'bxxx;
  endtask

  task automatic test_reset();
    rst = 1; #12; rst = 0;
    q.delete(); m_ovf = 0;
    @(posedge clk); #1;
    tests++;
    if ({out_valid, out_code, out_err, count, in_ready, overflow} !== {1'b0, 2'd0, 1'b0, CW'(0), 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset: got v=%0b code=%0d err=%0b cnt=%0d rdy=%0b ovf=%0b, want 0 0 0 0 1 0",
               out_valid, out_code, out_err, count, in_ready, overflow);
    end
  endtask

  task automatic test_basic();
    cycle(1, 3'b001, 0, 0);
    tests++;
    if (out_valid !== 1'b1 || out_code !== 2'd1) begin
      fails++; $display("FAIL latency: got v=%0b code=%0d, want 1 1", out_valid, out_code);
    end
    cycle(1, 3'b010, 0, 0);
    cycle(1, 3'b100, 0, 0);
    tests++;
    if (count !== CW'(3)) begin fails++; $display("FAIL basic_count: got %0d want 3", count); end
    for (int i = 1; i <= 3; i++) begin
      tests++;
      if (out_code !== 2'(i) || out_err !== 1'b0 || out_valid !== 1'b1) begin
        fails++; $display("FAIL basic_head%0d: got code=%0d err=%0b v=%0b, want %0d 0 1", i, out_code, out_err, out_valid, i);
      end
      cycle(0, 3'b000, 1, 0);
    end
    tests++;
    if (out_valid !== 1'b0 || count !== CW'(0) || out_code !== 2'd0) begin
      fails++; $display("FAIL basic_drain: got v=%0b cnt=%0d code=%0d, want 0 0 0", out_valid, count, out_code);
    end
  endtask

  task automatic test_multibit();
    cycle(1, 3'b000, 0, 0);
    tests++;
    if (out_valid !== 1'b0 || count !== CW'(0)) begin
      fails++; $display("FAIL zero_discard: got v=%0b cnt=%0d, want 0 0", out_valid, count);
    end
    cycle(1, 3'b011, 0, 0);
    cycle(1, 3'b111, 0, 0);
    tests++;
    if (count !== CW'(2) || out_code !== 2'd2 || out_err !== 1'b1) begin
      fails++; $display("FAIL multi_first: got cnt=%0d code=%0d err=%0b, want 2 2 1", count, out_code, out_err);
    end
    cycle(0, 3'b000, 1, 0);
    tests++;
    if (out_code !== 2'd3 || out_err !== 1'b1) begin
      fails++; $display("FAIL multi_second: got code=%0d err=%0b, want 3 1", out_code, out_err);
    end
    cycle(0, 3'b000, 1, 0);
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < DEPTH; i++) cycle(1, 3'b001 << (i % 3), 0, 0);
    tests++;
    if (in_ready !== 1'b0 || count !== CW'(DEPTH) || overflow !== 1'b0) begin
      fails++; $display("FAIL full: got rdy=%0b cnt=%0d ovf=%0b, want 0 %0d 0", in_ready, count, overflow, DEPTH);
    end
    cycle(1, 3'b100, 0, 0);
    tests++;
    if (overflow !== 1'b1 || count !== CW'(DEPTH)) begin
      fails++; $display("FAIL ovf_set: got ovf=%0b cnt=%0d, want 1 %0d", overflow, count, DEPTH);
    end
    cycle(0, 3'b000, 0, 1);
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
    cycle(1, 3'b010, 0, 1);
    tests++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %0b want 1", overflow); end
    cycle(1, 3'b010, 1, 0);
    tests++;
    if (count !== CW'(DEPTH - 1) || in_ready !== 1'b1 || out_code !== 2'(q[0] % 4)) begin
      fails++; $display("FAIL pop_full: got cnt=%0d rdy=%0b code=%0d, want %0d 1 %0d", count, in_ready, out_code, DEPTH - 1, q[0] % 4);
    end
    while (q.size() > 0) cycle(0, 3'b000, 1, 1);
    tests++;
    if (overflow !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL full_drain: got ovf=%0b v=%0b, want 0 0", overflow, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) begin
      cycle(1, 3'b001 << (k % 3), 1, 0);
      tests++;
      if (count !== CW'(1) || out_code !== 2'((k % 3) + 1) || out_err !== 1'b0) begin
        fails++; $display("FAIL stream%0d: got cnt=%0d code=%0d err=%0b, want 1 %0d 0", k, count, out_code, out_err, (k % 3) + 1);
      end
    end
    cycle(0, 3'b000, 1, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1, 3'b010, 0, 0);
    #2 rst = 1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || count !== CW'(0) || out_code !== 2'd0) begin
      fails++; $display("FAIL async_reset: got v=%0b cnt=%0d code=%0d, want 0 0 0", out_valid, count, out_code);
    end
    #2 rst = 0;
    q.delete(); m_ovf = 0;
    cycle(1, 3'b100, 0, 0);
    tests++;
    if (out_valid !== 1'b1 || out_code !== 2'd3 || count !== CW'(1)) begin
      fails++; $display("FAIL post_reset: got v=%0b code=%0d cnt=%0d, want 1 3 1", out_valid, out_code, count);
    end
    cycle(0, 3'b000, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      tests++;
      if ({out_valid, out_code, out_err, count, in_ready, overflow} !==
          {q.size() > 0, 2'(head() % 4), head() >= 4, CW'(q.size()), q.size() < DEPTH, m_ovf}) begin
        fails++;
        $display("FAIL random%0d: got v=%0b code=%0d err=%0b cnt=%0d rdy=%0b ovf=%0b, want v=%0b code=%0d err=%0b cnt=%0d rdy=%0b ovf=%0b",
                 i, out_valid, out_code, out_err, count, in_ready, overflow,
                 q.size() > 0, head() % 4, head() >= 4, q.size(), q.size() < DEPTH, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multibit();
    test_full_overflow();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
